lfsr_prbs_gen: RTL and testbench

//  Parametrised Fibonacci LFSR pseudo-random generator with ready/valid output.

---
 rtl/lfsr_prbs_gen.sv | 133 +++++++++++++
 tb/tb_lfsr_prbs_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/lfsr_prbs_gen.sv
// Fibonacci LFSR pseudo-random generator with a ready/valid output beat,
// run-time seed reload, all-zero lock-up recovery and period measurement.
module lfsr_prbs_gen #(
  parameter int                WIDTH = 8,
  parameter logic [WIDTH-1:0]  TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0]  SEED  = '1,
  parameter int                STEPS = 1,
  parameter int                CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             seed_err,
  output logic             lockup,
  output logic             wrap,
  output logic [CNT_W-1:0] period
);

  // Handshake: a beat transfers on a clock edge where out_valid && out_ready.
  // Once raised, out_valid and out_data stay stable until that transfer.
  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             seed_err_q, seed_err_d;
  logic             lockup_q, lockup_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] adv;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  always_comb begin
    adv = lfsr_q;
    for (int i = 0; i < STEPS; i++) begin
      adv = lfsr_step(adv);
    end
  end

  // Counter saturates at all-ones rather than wrapping.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign accept  = (state_q == ST_RUN) && out_ready;

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    seed_d     = seed_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    seed_err_d = 1'b0;
    lockup_d   = 1'b0;
    wrap_d     = 1'b0;

    if (seed_load) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      if (seed_in == '0) begin
        lfsr_d     = SEED;
        seed_d     = SEED;
        seed_err_d = 1'b1;
      end else begin
        lfsr_d = seed_in;
        seed_d = seed_in;
      end
    end else if (lfsr_q == '0) begin
      lfsr_d   = SEED;
      lockup_d = 1'b1;
      cnt_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (accept) begin
            lfsr_d = adv;
            if (!en) state_d = ST_IDLE;
            if (adv == seed_q) begin
              wrap_d   = 1'b1;
              period_d = cnt_inc;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= SEED;
      seed_q     <= SEED;
      cnt_q      <= '0;
      period_q   <= '0;
      seed_err_q <= 1'b0;
      lockup_q   <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      seed_q     <= seed_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      seed_err_q <= seed_err_d;
      lockup_q   <= lockup_d;
      wrap_q     <= wrap_d;
    end
  end

  assign out_valid = (state_q == ST_RUN);
  assign out_data  = lfsr_q;
  assign seed_err  = seed_err_q;
  assign lockup    = lockup_q;
  assign wrap      = wrap_q;
  assign period    = period_q;

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Directed bench for lfsr_prbs_gen: one-step and two-step instances,
// hand-computed sequences, stall, seed reload, wrap/period and reset.
module tb_lfsr_prbs_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic        seed_load;
  logic [7:0]  seed_in;
  logic        out_ready;

  logic        v1, v2;
  logic [7:0]  d1, d2;
  logic        se1, se2, lk1, lk2, wr1, wr2;
  logic [15:0] p1, p2;

  int n_checks;
  int n_fail;

  lfsr_prbs_gen #(.STEPS(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .out_ready(out_ready), .out_valid(v1), .out_data(d1), .seed_err(se1),
    .lockup(lk1), .wrap(wr1), .period(p1)
  );

  lfsr_prbs_gen #(.STEPS(2)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .out_ready(out_ready), .out_valid(v2), .out_data(d2), .seed_err(se2),
    .lockup(lk2), .wrap(wr2), .period(p2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    en        = 1'b0;
    seed_load = 1'b0;
    seed_in   = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, v1}, 32'd0);
    check("rst_data", {24'd0, d1}, 32'hFF);
    check("rst_period", {16'd0, p1}, 32'd0);
    check("rst_pulses", {29'd0, se1, lk1, wr1}, 32'd0);
    check("rst_data2", {24'd0, d2}, 32'hFF);
    rst = 1'b0;
  endtask

  // Runs beats with out_ready=1 until wrap; returns the beat count.
  task automatic run_to_wrap(output int n);
    n = 0;
    while (n < 400) begin
      tick();
      n++;
      if (wr1) break;
    end
  endtask

  logic [7:0] exp1 [6];
  logic [7:0] exp2 [6];
  int         nb;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp1 = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1};
    exp2 = '{8'hFF, 8'hFC, 8'hF0, 8'hC2, 8'h0B, 8'h2F};

    do_reset();

    // sequences at full throughput
    en        = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("seq1_valid", {31'd0, v1}, 32'd1);
      check("seq1_data", {24'd0, d1}, {24'd0, exp1[i]});
      check("seq2_data", {24'd0, d2}, {24'd0, exp2[i]});
    end

    // stall: data and valid frozen
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", {31'd0, v1}, 32'd1);
      check("stall_data1", {24'd0, d1}, 32'hE1);
      check("stall_data2", {24'd0, d2}, 32'h2F);
    end
    out_ready = 1'b1;
    tick();
    check("resume_data1", {24'd0, d1}, 32'hC2);
    check("resume_data2", {24'd0, d2}, 32'hBC);

    // full period from reset seed
    do_reset();
    en        = 1'b1;
    out_ready = 1'b1;
    tick();
    check("run_first", {24'd0, d1}, 32'hFF);
    run_to_wrap(nb);
    check("wrap_beats", nb, 32'd255);
    check("wrap_data", {24'd0, d1}, 32'hFF);
    check("wrap_period", {16'd0, p1}, 32'd255);
    tick();
    check("wrap_pulse_end", {31'd0, wr1}, 32'd0);

    // seed load during an accepted beat: load wins
    seed_load = 1'b1;
    seed_in   = 8'h5A;
    tick();
    seed_load = 1'b0;
    check("load_valid", {31'd0, v1}, 32'd0);
    check("load_data", {24'd0, d1}, 32'h5A);
    check("load_nowrap", {31'd0, wr1}, 32'd0);
    check("load_period", {16'd0, p1}, 32'd255);
    tick();
    check("load_first", {24'd0, d1}, 32'h5A);
    check("load_first_v", {31'd0, v1}, 32'd1);
    run_to_wrap(nb);
    check("wrap5a_beats", nb, 32'd255);
    check("wrap5a_data", {24'd0, d1}, 32'h5A);
    check("wrap5a_period", {16'd0, p1}, 32'd255);

    // zero seed rejected
    en        = 1'b0;
    seed_load = 1'b1;
    seed_in   = 8'h00;
    tick();
    seed_load = 1'b0;
    check("zseed_err", {31'd0, se1}, 32'd1);
    check("zseed_data", {24'd0, d1}, 32'hFF);
    check("zseed_valid", {31'd0, v1}, 32'd0);
    tick();
    check("zseed_err_end", {31'd0, se1}, 32'd0);
    check("zseed_idle", {31'd0, v1}, 32'd0);
    en = 1'b1;
    tick();
    check("zseed_first", {24'd0, d1}, 32'hFF);
    check("zseed_first_v", {31'd0, v1}, 32'd1);
    check("zseed_period", {16'd0, p1}, 32'd255);

    // en dropped while stalled
    en        = 1'b0;
    out_ready = 1'b0;
    repeat (2) begin
      tick();
      check("drop_hold_v", {31'd0, v1}, 32'd1);
      check("drop_hold_d", {24'd0, d1}, 32'hFF);
    end
    out_ready = 1'b1;
    tick();
    check("drop_acc_v", {31'd0, v1}, 32'd0);
    check("drop_acc_d", {24'd0, d1}, 32'hFE);
    tick();
    check("drop_idle_v", {31'd0, v1}, 32'd0);
    check("drop_idle_d", {24'd0, d1}, 32'hFE);

    // asynchronous reset mid-run
    en = 1'b1;
    tick();
    tick();
    check("pre_rst_data", {24'd0, d1}, 32'hFC);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, v1}, 32'd0);
    check("arst_data", {24'd0, d1}, 32'hFF);
    check("arst_period", {16'd0, p1}, 32'd0);
    check("lockup_quiet", {31'd0, lk1}, 32'd0);
    en        = 1'b0;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
